// File: rtl/dccm_arbiter.sv
// Two-master arbiter for the single DCCM port: core (m0) normally wins,
// DMA (m1) wins one tie after a bounded wait. Responses return one cycle later.
module dccm_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp_vld,
    output logic        m0_rsp_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rsp_vld,
    output logic        m1_rsp_err,
    output logic [31:0] m1_rdata,
    output logic        dccm_wr_en,
    output logic        dccm_rd_en,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_rd_addr,
    output logic [31:0] dccm_wr_data,
    input  logic [31:0] dccm_rd_data
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    typedef enum logic {CORE_PRIO, DMA_BOOST} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_rd_q, rsp_rd_d;
    logic               rsp_err_q, rsp_err_d;

    logic               m1_win, any_gnt, win_we, mis;
    logic [31:0]        win_addr, win_wdata, word_addr;

    always_comb begin
        m1_win    = m1_req && (!m0_req || state_q == DMA_BOOST);
        m0_gnt    = m0_req && !m1_win;
        m1_gnt    = m1_win;
        any_gnt   = m0_req || m1_req;
        win_we    = m1_win ? m1_we    : m0_we;
        win_addr  = m1_win ? m1_addr  : m0_addr;
        win_wdata = m1_win ? m1_wdata : m0_wdata;
        mis       = win_addr[1:0] != 2'b00;
        word_addr = {2'b00, win_addr[31:2]};

        // Misaligned accesses are accepted but never reach the memory.
        dccm_wr_en   = any_gnt && win_we && !mis;
        dccm_rd_en   = any_gnt && !win_we && !mis;
        dccm_wr_addr = dccm_wr_en ? word_addr : 32'h0;
        dccm_wr_data = dccm_wr_en ? win_wdata : 32'h0;
        dccm_rd_addr = dccm_rd_en ? word_addr : 32'h0;

        rsp_vld_d = any_gnt;
        rsp_id_d  = m1_win;
        rsp_rd_d  = dccm_rd_en;
        rsp_err_d = any_gnt && mis;

        wait_cnt_d = '0;
        if (m1_req && !m1_win)
            wait_cnt_d = (wait_cnt_q == LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;

        // Boost is entered only after a blocked cycle at a saturated count,
        // so m0 still wins the cycle in which the counter saturates.
        state_d = state_q;
        case (state_q)
            CORE_PRIO: if (m1_req && !m1_win && wait_cnt_q == LIM) state_d = DMA_BOOST;
            DMA_BOOST: if (m1_win || !m1_req) state_d = CORE_PRIO;
            default:   state_d = CORE_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CORE_PRIO;
            wait_cnt_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_rd_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign m0_rsp_vld = rsp_vld_q && !rsp_id_q;
    assign m1_rsp_vld = rsp_vld_q && rsp_id_q;
    assign m0_rsp_err = m0_rsp_vld && rsp_err_q;
    assign m1_rsp_err = m1_rsp_vld && rsp_err_q;
    assign m0_rdata   = (m0_rsp_vld && rsp_rd_q) ? dccm_rd_data : 32'h0;
    assign m1_rdata   = (m1_rsp_vld && rsp_rd_q) ? dccm_rd_data : 32'h0;

endmodule

// File: tb/tb_dccm_arbiter.sv
// Bench for dccm_arbiter: vector table, directed corner sequences and a
// randomized run against a streak-counting reference model.
module tb_dccm_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rsp_vld, m0_rsp_err, m1_gnt, m1_rsp_vld, m1_rsp_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dccm_wr_en, dccm_rd_en;
    logic [31:0] dccm_wr_addr, dccm_rd_addr, dccm_wr_data, dccm_rd_data;
    logic        mem_clr;
    logic [31:0] mem [64];

    int nchk = 0;
    int errs = 0;

    dccm_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rsp_vld(m0_rsp_vld), .m0_rsp_err(m0_rsp_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rsp_vld(m1_rsp_vld), .m1_rsp_err(m1_rsp_err), .m1_rdata(m1_rdata),
        .dccm_wr_en(dccm_wr_en), .dccm_rd_en(dccm_rd_en),
        .dccm_wr_addr(dccm_wr_addr), .dccm_rd_addr(dccm_rd_addr),
        .dccm_wr_data(dccm_wr_data), .dccm_rd_data(dccm_rd_data)
    );

    always #5 clk = ~clk;

    // Simple synchronous memory standing in for the ccm array.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (dccm_wr_en) begin
            mem[dccm_wr_addr[5:0]] <= dccm_wr_data;
        end
        if (dccm_rd_en) dccm_rd_data <= mem[dccm_rd_addr[5:0]];
    end

    task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rsp_bits();
        return {m0_rsp_vld, m0_rsp_err, m1_rsp_vld, m1_rsp_err};
    endfunction

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, wen, ren, err;
        logic [31:0] waddr, raddr, wdata;
    } vec_t;

    // Reference-model state for the random phase.
    int          streak;
    logic [31:0] smem [64];
    logic        p_vld, p_id, p_err, p_rd;
    logic [31:0] p_data;

    initial begin
        vec_t v [7];
        logic        r0, w0, r1, w1;
        logic [31:0] a0, d0, a1, d1;

        rst_n = 1'b0; mem_clr = 1'b1; idle();
        repeat (3) adv();
        settle();
        chk("reset_rsp", {164'h0, rsp_bits()}, 168'h0);
        chk("reset_rdata", {104'h0, m0_rdata, m1_rdata}, 168'h0);
        chk("reset_comb", {98'h0, m0_gnt, m1_gnt, dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr}, 168'h0);
        adv();
        rst_n = 1'b1; mem_clr = 1'b0;
        adv();

        // r0 w0 a0 d0 r1 w1 a1 d1 | g0 g1 wen ren err waddr raddr wdata
        v[0] = '{0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,        32'h0};
        v[1] = '{1, 1, 32'h104,      32'hA5A50001, 0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 32'h41, 32'h0,        32'hA5A50001};
        v[2] = '{0, 0, 32'h0,        32'h0,        1, 0, 32'hFFFFFFFC, 32'h0,        0, 1, 0, 1, 0, 32'h0,  32'h3FFFFFFF, 32'h0};
        v[3] = '{1, 0, 32'h8,        32'h0,        1, 1, 32'hC,        32'h11111111, 1, 0, 0, 1, 0, 32'h0,  32'h2,        32'h0};
        v[4] = '{0, 0, 32'h0,        32'h0,        1, 1, 32'h13,       32'h22222222, 0, 1, 0, 0, 1, 32'h0,  32'h0,        32'h0};
        v[5] = '{1, 1, 32'h1,        32'h33333333, 1, 1, 32'h4,        32'h44444444, 1, 0, 0, 0, 1, 32'h0,  32'h0,        32'h0};
        v[6] = '{0, 0, 32'h0,        32'h0,        1, 1, 32'h200,      32'hCAFEF00D, 0, 1, 1, 0, 0, 32'h80, 32'h0,        32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            drive(v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
            settle();
            chk($sformatf("vec%0d_comb", i),
                {68'h0, m0_gnt, m1_gnt, dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data},
                {68'h0, v[i].g0, v[i].g1, v[i].wen, v[i].ren, v[i].waddr, v[i].raddr, v[i].wdata});
            adv(); idle(); settle();
            chk($sformatf("vec%0d_rsp", i), {164'h0, rsp_bits()},
                {164'h0, v[i].g0, v[i].g0 & v[i].err, v[i].g1, v[i].g1 & v[i].err});
            adv();
        end

        // Single read by m0 after preloading word 0x10.
        drive(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
        settle();
        chk("preload_wr", {103'h0, m0_gnt, dccm_wr_en, dccm_wr_addr, dccm_wr_data}, {103'h0, 2'b11, 32'h10, 32'hDEADBEEF});
        adv(); drive(1, 0, 32'h40, 0, 0, 0, 0, 0); settle();
        chk("m0_rd_gnt", {134'h0, m0_gnt, dccm_rd_en, dccm_rd_addr}, {134'h0, 2'b11, 32'h10});
        adv(); idle(); settle();
        chk("m0_rd_rsp", {132'h0, rsp_bits(), m0_rdata}, {132'h0, 4'b1000, 32'hDEADBEEF});

        // Write then read by m1.
        adv(); drive(0, 0, 0, 0, 1, 1, 32'h80, 32'h12345678); settle();
        chk("m1_wr", {102'h0, m1_gnt, dccm_wr_en, dccm_wr_addr, dccm_wr_data}, {102'h0, 2'b11, 32'h20, 32'h12345678});
        adv(); drive(0, 0, 0, 0, 1, 0, 32'h80, 0); settle();
        chk("m1_wr_rsp", {132'h0, rsp_bits(), m1_rdata}, {132'h0, 4'b0010, 32'h0});
        adv(); idle(); settle();
        chk("m1_rd_rsp", {132'h0, rsp_bits(), m1_rdata}, {132'h0, 4'b0010, 32'h12345678});
        adv();

        // Starvation bound under continuous contention: m0 x5 then m1.
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0); settle();
            chk($sformatf("starve_c%0d", i), {166'h0, m0_gnt, m1_gnt}, (i % 6 == 5) ? 168'h1 : 168'h2);
            adv();
        end
        idle(); adv();

        // Misaligned read.
        drive(1, 0, 32'h42, 0, 0, 0, 0, 0); settle();
        chk("mis_gnt", {134'h0, m0_gnt, dccm_rd_en, dccm_rd_addr}, {134'h0, 2'b10, 32'h0});
        adv(); idle(); settle();
        chk("mis_rsp", {132'h0, rsp_bits(), m0_rdata}, {132'h0, 4'b1100, 32'h0});
        adv();

        // Counter clear: 3 blocked cycles, 1 cycle off, then a fresh 5-cycle wait.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0); settle();
            chk($sformatf("clr_pre%0d", i), {166'h0, m0_gnt, m1_gnt}, 168'h2);
            adv();
        end
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0); adv();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0); settle();
            chk($sformatf("clr_post%0d", i), {166'h0, m0_gnt, m1_gnt}, (i == 5) ? 168'h1 : 168'h2);
            adv();
        end
        idle(); adv();

        // Reset right after an m0 read grant, with the arbiter primed to boost m1.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h40, 0, 1, 0, 32'h4, 0); settle();
            chk($sformatf("rst_pre%0d", i), {166'h0, m0_gnt, m1_gnt}, 168'h2);
            adv();
        end
        rst_n = 1'b0; idle(); settle();
        chk("rst_during", {100'h0, rsp_bits(), m0_rdata, m1_rdata}, 168'h0);
        adv(); rst_n = 1'b1; settle();
        chk("rst_after", {100'h0, rsp_bits(), m0_rdata, m1_rdata}, 168'h0);
        adv(); drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0); settle();
        chk("rst_core_prio", {166'h0, m0_gnt, m1_gnt}, 168'h2);
        adv(); idle(); adv();

        // Randomized run against the reference model.
        mem_clr = 1'b1; adv(); mem_clr = 1'b0;
        for (int i = 0; i < 64; i++) smem[i] = 32'h0;
        streak = 0; p_vld = 0; p_id = 0; p_err = 0; p_rd = 0; p_data = 0;
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 400; c++) begin
            logic        g0, g1, wwe, wmis, any;
            logic [31:0] wa, wd, waddr;
            logic [167:0] exp, act;
            if (!r0 || $urandom_range(0, 15) == 0) begin
                r0 = $urandom_range(0, 3) != 0; w0 = $urandom_range(0, 1) == 1;
                a0 = {24'h0, 6'($urandom_range(0, 63)), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                d0 = $urandom;
            end
            if (!r1 || $urandom_range(0, 15) == 0) begin
                r1 = $urandom_range(0, 3) != 0; w1 = $urandom_range(0, 1) == 1;
                a1 = {24'h0, 6'($urandom_range(0, 63)), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                d1 = $urandom;
            end
            // m1 wins a tie once it has been refused more than LIM cycles in a row.
            g1 = r1 && (!r0 || streak > LIM);
            g0 = r0 && !g1;
            any = g0 || g1;
            wwe = g1 ? w1 : w0; wa = g1 ? a1 : a0; wd = g1 ? d1 : d0;
            wmis = wa % 4 != 0;
            waddr = wa / 4;
            exp = {g0, g1,
                   any && wwe && !wmis, any && !wwe && !wmis,
                   (any && wwe && !wmis) ? waddr : 32'h0,
                   (any && !wwe && !wmis) ? waddr : 32'h0,
                   (any && wwe && !wmis) ? wd : 32'h0,
                   p_vld && !p_id, p_vld && p_id, p_vld && !p_id && p_err, p_vld && p_id && p_err,
                   (p_vld && !p_id && p_rd) ? p_data : 32'h0,
                   (p_vld && p_id && p_rd) ? p_data : 32'h0};
            drive(r0, w0, a0, d0, r1, w1, a1, d1);
            settle();
            act = {m0_gnt, m1_gnt, dccm_wr_en, dccm_rd_en, dccm_wr_addr, dccm_rd_addr, dccm_wr_data,
                   m0_rsp_vld, m1_rsp_vld, m0_rsp_err, m1_rsp_err, m0_rdata, m1_rdata};
            chk($sformatf("rand_c%0d", c), act, exp);
            p_vld = any; p_id = g1; p_err = any && wmis; p_rd = any && !wwe && !wmis;
            p_data = smem[waddr[5:0]];
            if (any && wwe && !wmis) smem[waddr[5:0]] = wd;
            streak = (r1 && !g1) ? streak + 1 : 0;
            if (g0) r0 = 0;
            if (g1) r1 = 0;
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
        $finish;
    end
endmodule
